moving_average_filter: RTL and testbench

Parametrised multi-channel moving-average (boxcar) low-pass filter for the audio path. It replaces the fixed 16-tap mono averager with configurable window depth, channel count and sample width. It adds full-precision accumulation, window-fill status, bypass and synchronous clear. It sits between the audio codec deserialiser and downstream DSP/effects, and is clocked by the system clock with a per-sample strobe.

---
 rtl/moving_average_filter.sv | 102 ++++++++++
 tb/tb_moving_average_filter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_filter.sv
`default_nettype none
// ============================================================================
// Module      : moving_average_filter
// Description : Multi-channel boxcar (moving-average) low-pass filter with
//               full-precision running sums, window-fill status, bypass and
//               synchronous clear. One sample per channel per enable strobe.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module moving_average_filter #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_DEPTH = 4,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           enable,
  input  logic                           bypass,
  input  logic [CHANNELS*DATA_WIDTH-1:0] signal,
  output logic [CHANNELS*DATA_WIDTH-1:0] result,
  output logic                           result_valid,
  output logic                           primed
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int ACC_W  = DATA_WIDTH + LOG2_DEPTH;
  // A one-entry window still needs a 1-bit pointer; it simply never moves.
  localparam int PTR_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int FILL_W = LOG2_DEPTH + 1;

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_next;
  logic [PTR_W-1:0]  w_ptr_next;

  assign w_fill_next = (r_fill == FULL) ? FULL : (r_fill + FILL_W'(1));
  assign w_ptr_next  = (r_wr_ptr == LAST_PTR) ? '0 : (r_wr_ptr + PTR_W'(1));

  // Shared write pointer, fill counter and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      result_valid <= 1'b0;
      primed       <= 1'b0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      result_valid <= 1'b0;
      primed       <= 1'b0;
    end else if (enable) begin
      r_wr_ptr     <= w_ptr_next;
      r_fill       <= w_fill_next;
      result_valid <= 1'b1;
      // Rises on the edge that accepts the DEPTH-th sample.
      primed       <= (w_fill_next == FULL);
    end else begin
      result_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] r_hist [DEPTH];
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [DATA_WIDTH-1:0] r_result;
    logic signed [DATA_WIDTH-1:0] w_x;
    logic signed [DATA_WIDTH-1:0] w_oldest;
    logic signed [ACC_W-1:0]      w_acc_next;
    logic signed [DATA_WIDTH-1:0] w_avg;

    assign w_x        = signal[c*DATA_WIDTH +: DATA_WIDTH];
    assign w_oldest   = r_hist[r_wr_ptr];
    // Signed size casts sign-extend; the sum of DEPTH samples always fits.
    assign w_acc_next = r_acc + ACC_W'(w_x) - ACC_W'(w_oldest);
    // Arithmetic shift floors toward minus infinity; the quotient fits DATA_WIDTH.
    assign w_avg      = DATA_WIDTH'(w_acc_next >>> LOG2_DEPTH);

    // Per-channel history, running sum and output register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        r_acc    <= '0;
        r_result <= '0;
      end else if (clear) begin
        for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        r_acc    <= '0;
        r_result <= '0;
      end else if (enable) begin
        r_hist[r_wr_ptr] <= w_x;
        r_acc            <= w_acc_next;
        r_result         <= bypass ? w_x : w_avg;
      end
    end

    assign result[c*DATA_WIDTH +: DATA_WIDTH] = r_result;
  end : g_ch

endmodule : moving_average_filter
`default_nettype wire

// File: tb/tb_moving_average_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_moving_average_filter
// Description : Scoreboard bench for moving_average_filter (default params).
//               Stimulus pushes hand-computed expectations; a monitor pops and
//               compares on every result_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moving_average_filter;

  localparam int DW = 24;
  localparam int L2 = 4;
  localparam int CH = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic            enable = 1'b0;
  logic            bypass = 1'b0;
  logic [CH*DW-1:0] signal = '0;
  logic [CH*DW-1:0] result;
  logic            result_valid;
  logic            primed;

  moving_average_filter #(
    .DATA_WIDTH(DW),
    .LOG2_DEPTH(L2),
    .CHANNELS  (CH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .enable      (enable),
    .bypass      (bypass),
    .signal      (signal),
    .result      (result),
    .result_valid(result_valid),
    .primed      (primed)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [DW-1:0] e0;
    logic signed [DW-1:0] e1;
    logic                 ep;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result_valid=1, expected 0 (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("result_ch0", longint'($signed(result[DW-1:0])), longint'(mon_e.e0));
        check("result_ch1", longint'($signed(result[2*DW-1:DW])), longint'(mon_e.e1));
        check("primed", longint'(primed), longint'(mon_e.ep));
      end
    end
  end

  // Issue one sample (called at posedge+1), then idle for gap cycles
  task automatic send(input longint s0, input longint s1, input logic byp,
                      input longint e0, input longint e1, input logic ep,
                      input int gap);
    exp_t e;
    e.e0 = e0[DW-1:0];
    e.e1 = e1[DW-1:0];
    e.ep = ep;
    signal = {s1[DW-1:0], s0[DW-1:0]};
    bypass = byp;
    enable = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    enable = 1'b0;
    bypass = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    idle(3);
    check("reset_result", longint'(result), 0);
    check("reset_valid", longint'(result_valid), 0);
    check("reset_primed", longint'(primed), 0);
    reset_n = 1'b1;
    idle(1);

    // 1: ramp-up with strobes every 4th cycle
    for (int k = 1; k <= 16; k++)
      send(1600, -1600, 1'b0, 100 * k, -100 * k, k >= 16, 3);

    // 2: input drops to zero, ramp down, primed holds
    for (int k = 1; k <= 16; k++)
      send(0, 0, 1'b0, 1600 - 100 * k, -(1600 - 100 * k), 1'b1, 1);

    // 3: full-scale extremes, back-to-back
    for (int k = 1; k <= 16; k++)
      send(8388607, -8388608, 1'b0, (longint'(k) * 8388607) / 16,
           -524288 * longint'(k), 1'b1, 0);
    idle(2);

    // 4: floor rounding of a single -1 sample
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send(-1, 0, 1'b0, -1, 0, 1'b0, 1);
    for (int k = 2; k <= 16; k++)
      send(0, 0, 1'b0, -1, 0, k >= 16, 1);
    send(0, 0, 1'b0, 0, 0, 1'b1, 1);

    // 5: bypass while the averaging state keeps updating
    for (int k = 1; k <= 16; k++)
      send(1600, -1600, 1'b0, 100 * k, -100 * k, 1'b1, 1);
    for (int k = 1; k <= 4; k++)
      send(3200, -3200, 1'b1, 3200, -3200, 1'b1, 1);
    send(3200, -3200, 1'b0, 2100, -2100, 1'b1, 2);

    // 6: clear coincident with enable discards the sample
    signal = {24'sd9999, 24'sd9999};
    enable = 1'b1;
    clear  = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    clear  = 1'b0;
    @(negedge clk);
    check("clear_result", longint'(result), 0);
    check("clear_valid", longint'(result_valid), 0);
    check("clear_primed", longint'(primed), 0);
    @(posedge clk);
    #1;
    send(1600, -1600, 1'b0, 100, -100, 1'b0, 2);
    // Continuous enable after a clear: one result per cycle
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int k = 1; k <= 16; k++)
      send(1600, -1600, 1'b0, 100 * k, -100 * k, k >= 16, 0);
    @(negedge clk);
    #1;
    check("continuous_no_bubbles_pending", longint'(sb.size()), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-stream
    reset_n = 1'b0;
    #1;
    check("async_reset_result", longint'(result), 0);
    check("async_reset_primed", longint'(primed), 0);
    check("async_reset_valid", longint'(result_valid), 0);
    idle(2);
    reset_n = 1'b1;

    // Drain (bounded)
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    check("scoreboard_empty", longint'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_moving_average_filter
`default_nettype wire
